// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, instruction encodings and the fetch state enum
// for the 16-bit pipelined processor.
package cpu_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] NOP_INSTR  = 16'h0800;
  localparam logic [WORD_W-1:0] HALT_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry holding register that parks a fetched word (and its
// PC+2) while decode is stalled.
module fetch_skid
  import cpu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic              i_clear,
  input  logic [WORD_W-1:0] i_instr,
  input  logic [WORD_W-1:0] i_pc_plus2,
  output logic [WORD_W-1:0] o_instr,
  output logic [WORD_W-1:0] o_pc_plus2,
  output logic              o_full
);

  logic              r_full;
  logic [WORD_W-1:0] r_instr;
  logic [WORD_W-1:0] r_pc_plus2;

  // A redirect must beat a same-cycle load so that no wrong-path word survives.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full     <= 1'b0;
      r_instr    <= '0;
      r_pc_plus2 <= '0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full     <= 1'b1;
      r_instr    <= i_instr;
      r_pc_plus2 <= i_pc_plus2;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus2 = r_pc_plus2;
  assign o_full     = r_full;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, imem req/ready handshake and IF/ID register for decode.
// Optional FETCH_ALIGN_CHECK_EN: an odd redirect target sets sticky err and halts.
module fetch_stage #(
  parameter logic [cpu_pkg::WORD_W-1:0] RESET_PC  = 16'h0000,
  parameter logic [cpu_pkg::WORD_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [cpu_pkg::WORD_W-1:0] redirect_pc,
  input  logic                       halt_in,
  output logic                       imem_req,
  output logic [cpu_pkg::WORD_W-1:0] imem_addr,
  input  logic [cpu_pkg::WORD_W-1:0] imem_rdata,
  input  logic                       imem_ready,
  output logic [cpu_pkg::WORD_W-1:0] instr,
  output logic [cpu_pkg::WORD_W-1:0] pc_plus2,
  output logic                       valid,
  output logic                       err
);

  import cpu_pkg::*;

  fetch_state_t      r_state;
  logic              r_kill;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_req_addr;
  logic [WORD_W-1:0] r_instr;
  logic [WORD_W-1:0] r_pc_plus2;
  logic              r_valid;

  logic              w_active;
  logic              w_issue;
  logic              w_capture;
  logic              w_skid_load;
  logic              w_skid_drain;
  logic              w_skid_clear;
  logic              w_skid_full;
  logic [WORD_W-1:0] w_skid_instr;
  logic [WORD_W-1:0] w_skid_pc_plus2;
  logic [WORD_W-1:0] w_pc_next;
  logic [WORD_W-1:0] w_target;
  logic              w_misaligned;

  assign w_target  = {redirect_pc[WORD_W-1:1], 1'b0};
  assign w_pc_next = r_pc + 16'd2;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misaligned = redirect_pc[0];
`else
  logic w_unused_pc_lsb;
  assign w_unused_pc_lsb = redirect_pc[0];
  assign w_misaligned    = 1'b0;
`endif

  // Gating with rst keeps the request low for the whole reset window; a new
  // request is never started in a cycle that is about to redirect or halt.
  assign w_active  = rst && (r_state != HALTED);
  assign w_issue   = w_active && (r_state == FETCH) && !stall && !w_skid_full &&
                     !redirect && !halt_in;
  assign imem_req  = w_issue || (w_active && (r_state == WAIT));
  assign imem_addr = (r_state == WAIT) ? r_req_addr : r_pc;

  assign w_capture    = imem_req && imem_ready && !r_kill && !redirect && !halt_in;
  assign w_skid_load  = w_capture && stall;
  assign w_skid_drain = w_active && w_skid_full && !stall && !redirect && !halt_in;
  assign w_skid_clear = w_active && redirect;

  fetch_skid u_skid (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_load     (w_skid_load),
    .i_drain    (w_skid_drain),
    .i_clear    (w_skid_clear),
    .i_instr    (imem_rdata),
    .i_pc_plus2 (w_pc_next),
    .o_instr    (w_skid_instr),
    .o_pc_plus2 (w_skid_pc_plus2),
    .o_full     (w_skid_full)
  );

  // Priority inside a live state: redirect, then halt, then capture/drain/bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= FETCH;
      r_kill     <= 1'b0;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_pc_plus2 <= '0;
      r_valid    <= 1'b0;
    end else if (r_state != HALTED) begin
      if (redirect) begin
        r_pc    <= w_target;
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
        if (w_misaligned) begin
          r_state <= HALTED;
          r_kill  <= 1'b0;
        end else if ((r_state == WAIT) && !imem_ready) begin
          r_state <= WAIT;
          r_kill  <= 1'b1;
        end else begin
          r_state <= FETCH;
          r_kill  <= 1'b0;
        end
      end else if (halt_in) begin
        r_state <= HALTED;
        r_kill  <= 1'b0;
      end else begin
        if (w_capture) begin
          r_pc <= w_pc_next;
        end
        if (w_capture && !stall) begin
          r_instr    <= imem_rdata;
          r_pc_plus2 <= w_pc_next;
          r_valid    <= 1'b1;
        end else if (!stall && w_skid_full) begin
          r_instr    <= w_skid_instr;
          r_pc_plus2 <= w_skid_pc_plus2;
          r_valid    <= 1'b1;
        end else if (!stall) begin
          r_instr <= NOP_INSTR;
          r_valid <= 1'b0;
        end
        if ((r_state == FETCH) && w_issue && !imem_ready) begin
          r_state    <= WAIT;
          r_req_addr <= r_pc;
        end else if ((r_state == WAIT) && imem_ready) begin
          r_state <= FETCH;
          r_kill  <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if ((r_state != HALTED) && redirect && w_misaligned) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign instr    = r_instr;
  assign pc_plus2 = r_pc_plus2;
  assign valid    = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios with a wait-state memory model and a
// scoreboard queue of expected IF/ID contents.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  typedef struct packed {
    logic [15:0] ins;
    logic [15:0] pc2;
  } sbEntry_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt_in;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [15:0] instr;
  logic [15:0] pc_plus2;
  logic        valid;
  logic        err;

  int vectors;
  int miscompares;

  sbEntry_t    sbQ[$];
  logic [15:0] benchPc;
  logic [15:0] pendAddr;
  logic        benchPending;
  logic        benchKill;
  logic        benchHalted;
  logic [15:0] expInstr;
  logic [15:0] expPc2;
  logic        expValid;
  logic        expErr;
  int          reqCnt;
  int          memWait;
  logic        sawReq;
  logic [15:0] sawAddr;

  fetch_stage #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0800)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_in     (halt_in),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .instr       (instr),
    .pc_plus2    (pc_plus2),
    .valid       (valid),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] memFn(input logic [15:0] a);
    return 16'hC123 + {1'b0, a[15:1]};
  endfunction

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check16("instr", instr, expInstr);
    check16("pc_plus2", pc_plus2, expPc2);
    check1("valid", valid, expValid);
    check1("err", err, expErr);
  endtask

  task automatic doReset();
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    halt_in     = 1'b0;
    imem_ready  = 1'b0;
    imem_rdata  = 16'h0000;
    #2;
    check1("rst_req", imem_req, 1'b0);
    check16("rst_addr", imem_addr, 16'h0000);
    check16("rst_instr", instr, NOP);
    check16("rst_pc_plus2", pc_plus2, 16'h0000);
    check1("rst_valid", valid, 1'b0);
    check1("rst_err", err, 1'b0);
    sbQ.delete();
    benchPc      = 16'h0000;
    pendAddr     = 16'h0000;
    benchPending = 1'b0;
    benchKill    = 1'b0;
    benchHalted  = 1'b0;
    expInstr     = NOP;
    expPc2       = 16'h0000;
    expValid     = 1'b0;
    expErr       = 1'b0;
    reqCnt       = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // One clock cycle: drive inputs, answer the request, update the expectation, check after the edge.
  task automatic applyStimulus(input logic st, input logic rd, input logic [15:0] rpc, input logic hlt);
    sbEntry_t    e;
    logic [15:0] tgt;
    logic        odd;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    halt_in     = hlt;
    imem_ready  = 1'b0;
    imem_rdata  = 16'h0000;
    #1;
    sawReq  = imem_req;
    sawAddr = imem_addr;
    if (imem_req) begin
      if (!benchPending) begin
        pendAddr     = benchPc;
        benchPending = 1'b1;
      end
      check16("imem_addr", imem_addr, pendAddr);
      if (reqCnt >= memWait) begin
        imem_ready = 1'b1;
        imem_rdata = memFn(imem_addr);
        reqCnt     = 0;
      end else begin
        reqCnt++;
      end
    end else begin
      reqCnt = 0;
    end
    if (!benchHalted) begin
      if (rd) begin
        tgt = {rpc[15:1], 1'b0};
`ifdef FETCH_ALIGN_CHECK_EN
        odd = rpc[0];
`else
        odd = 1'b0;
`endif
        benchPc  = tgt;
        expInstr = NOP;
        expValid = 1'b0;
        sbQ.delete();
        if (odd) begin
          expErr       = 1'b1;
          benchHalted  = 1'b1;
          benchPending = 1'b0;
          benchKill    = 1'b0;
        end else if (imem_req && !imem_ready) begin
          benchKill = 1'b1;
        end else begin
          benchKill    = 1'b0;
          benchPending = 1'b0;
        end
      end else if (hlt) begin
        benchHalted  = 1'b1;
        benchPending = 1'b0;
        benchKill    = 1'b0;
      end else begin
        if (imem_ready) begin
          if (benchKill) begin
            benchKill = 1'b0;
          end else begin
            e.ins = memFn(pendAddr);
            e.pc2 = pendAddr + 16'd2;
            sbQ.push_back(e);
            benchPc = pendAddr + 16'd2;
          end
          benchPending = 1'b0;
        end
        if (!st) begin
          if (sbQ.size() > 0) begin
            e        = sbQ.pop_front();
            expInstr = e.ins;
            expPc2   = e.pc2;
            expValid = 1'b1;
          end else begin
            expInstr = NOP;
            expValid = 1'b0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    memWait     = 0;
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    halt_in     = 1'b0;
    imem_ready  = 1'b0;
    imem_rdata  = 16'h0000;
    @(posedge clk);
    #1;

    $display("[TB] zero-wait fetch");
    doReset();
    memWait = 0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    check1("first_req", sawReq, 1'b1);
    check16("zw_instr0", instr, 16'hC123);
    check16("zw_pc2_0", pc_plus2, 16'h0002);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    check16("zw_instr1", instr, 16'hC124);
    check16("zw_pc2_1", pc_plus2, 16'h0004);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    check16("stall_hold_instr", instr, 16'hC124);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    check16("after_stall_instr", instr, 16'hC125);

    $display("[TB] two-cycle wait memory");
    doReset();
    memWait = 2;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      check1("wait_req_held", sawReq, 1'b1);
      check16("wait_addr_held", sawAddr, 16'h0000);
    end
    check1("wait_valid_pulse", valid, 1'b1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    end

    $display("[TB] stall with response in flight");
    doReset();
    memWait = 1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      check1("stall_valid_low", valid, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    check16("skid_drain_instr", instr, 16'hC123);
    check1("skid_drain_valid", valid, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    check16("no_dup_instr", instr, 16'hC124);

    $display("[TB] redirect during WAIT");
    doReset();
    memWait = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    end
    memWait = 3;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    check16("wait_addr_6", sawAddr, 16'h0006);
    applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    check1("stale_dropped", valid, 1'b0);
    memWait = 0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    check16("redir_addr", sawAddr, 16'h0100);
    check16("redir_instr", instr, 16'hC1A3);
    check16("redir_pc2", pc_plus2, 16'h0102);
    applyStimulus(1'b0, 1'b1, 16'h0200, 1'b0);
    check1("redir_bubble", valid, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    check16("redir_next_addr", sawAddr, 16'h0200);
    memWait = 1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0300, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    check16("redir_ready_addr", sawAddr, 16'h0300);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    check16("redir_ready_instr", instr, 16'hC2A3);

    $display("[TB] halt");
    doReset();
    memWait = 0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, (i == 5), 16'h0040, 1'b0);
      check1("halt_req_low", sawReq, 1'b0);
    end
    check16("halt_frozen_instr", instr, 16'hC124);

    $display("[TB] PC wrap and odd redirect");
    doReset();
    memWait = 0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'hFFFE, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    check16("wrap_addr", sawAddr, 16'hFFFE);
    check16("wrap_pc2", pc_plus2, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    check16("wrap_next_addr", sawAddr, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h0101, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
    check1("odd_err", err, 1'b1);
    check1("odd_req_low", sawReq, 1'b0);
`else
    check1("odd_err", err, 1'b0);
    check16("odd_addr_forced", sawAddr, 16'h0100);
`endif
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit pipelined processor: holds the PC, runs a req/ready handshake with instruction memory, and drives the IF/ID pipeline register that supplies `instr` to the decode stage. It absorbs stalls from the hazard unit, flushes on redirects from execute, and stops fetching when decode reports HALT.

## Interface
Parameters:
- `RESET_PC`, 16'h0000: PC loaded on reset.
- `NOP_INSTR`, 16'h0800: bubble encoding driven on `instr` when the stage is empty or flushed.

Ports:
- `clk`  in  1: the only clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `stall`  in  1: hazard unit; hold IF/ID and PC.
- `redirect`  in  1: taken branch/jump from execute.
- `redirect_pc`  in  16: redirect target.
- `halt_in`  in  1: decode has a valid HALT in IF/ID.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  16: fetch address (= PC).
- `imem_rdata`  in  16: instruction word, valid when `imem_ready`=1.
- `imem_ready`  in  1: request accepted and data returned this cycle.
- `instr`  out  16: IF/ID instruction, to decode.
- `pc_plus2`  out  16: IF/ID PC+2, for link and branch base.
- `valid`  out  1: IF/ID holds a real instruction.
- `err`  out  1: sticky fetch error.

## Operation
- State machine: FETCH, WAIT, HALTED. Flag `kill` marks an in-flight response to be discarded.
- FETCH:
  - `imem_req`=1 and `imem_addr`=PC unless `stall`=1 or the holding register is full.
  - If `imem_ready` arrives in the same cycle, capture the word. Otherwise go to WAIT.
- WAIT:
  - `imem_req` and `imem_addr` stay stable until `imem_ready`.
  - On `imem_ready`, capture the word and return to FETCH.
- Capture:
  - If `stall`=0: `instr`←`imem_rdata`, `pc_plus2`←PC+2, `valid`←1, PC←PC+2.
  - If `stall`=1: the word goes to a one-entry holding register and PC←PC+2.
  - The holding register drains into IF/ID on the first cycle with `stall`=0. No new request issues while it is full.
- `stall`=1 with nothing captured: IF/ID holds its value, PC holds.
- `stall`=0 with nothing captured and the holding register empty: IF/ID loads a bubble (`instr`=`NOP_INSTR`, `valid`=0).
- Redirect has the highest priority and wins over `stall`, `halt_in` and capture. It performs all of the following:
  - PC←`redirect_pc`.
  - IF/ID←bubble.
  - Holding register cleared.
  - If a request is outstanding and `imem_ready`=0 this cycle: set `kill` and stay in WAIT. The next `imem_ready` is discarded, `kill` clears, and the state goes to FETCH.
  - If `imem_ready`=1 in the redirect cycle: the data is discarded and the state goes to FETCH.
- `halt_in`=1 without redirect:
  - Go to HALTED, `imem_req`=0, IF/ID frozen.
  - A response still in flight is absorbed and discarded.
  - HALTED is left only by reset; `redirect` is ignored in HALTED.
- Arithmetic is modulo 2^16: PC 16'hFFFE + 2 wraps to 16'h0000. PC bit 0 is always 0.

## Timing
- Reset values: PC=`RESET_PC`, state FETCH, `instr`=`NOP_INSTR`, `valid`=0, `pc_plus2`=0, `imem_req`=0, `err`=0, `kill`=0, holding register empty.
- First request is in the first cycle after `rst` deasserts. `imem_req` is registered-safe: low while `rst`=0.
- With zero-wait memory (`imem_ready` in the request cycle), throughput is one instruction per cycle and IF/ID updates on the next edge (1-cycle latency).
- With N wait cycles, IF/ID updates one cycle after `imem_ready`.
- Redirect in cycle T: `imem_addr`=`redirect_pc` and `valid`=0 in T+1, unless a killed response is pending.
- Reset asserted mid-handshake returns the stage to reset values immediately. Memory must drop any outstanding request on reset.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined: a redirect with `redirect_pc[0]`=1 sets `err` (sticky until reset) and enters HALTED with IF/ID bubbled.
- Undefined: `redirect_pc[0]` is forced to 0 and `err` is tied to 0.

## Structure
- Shared package `cpu_pkg`: `WORD_W`=16, `NOP_INSTR`, `HALT_INSTR`=16'h0000, and the fetch state enum `fetch_state_t` (FETCH, WAIT, HALTED).
- Sub-module `fetch_skid`: the one-entry holding register, with load, drain and clear ports and the full flag.

## Test plan
- Zero-wait memory returning 16'hC123, 16'hC124 at 0x0000 and 0x0002 -> `instr` sequence C123, C124 on consecutive cycles, `pc_plus2`=0x0002 then 0x0004.
- Two-cycle wait memory -> `imem_addr` held at 0x0000 for 3 cycles, `valid` pulses once per fetch, with bubbles in between.
- `stall`=1 for 3 cycles with a response arriving during the stall -> word is held, IF/ID unchanged, word appears the cycle after `stall` falls, and no instruction is lost or duplicated.
- Redirect to 0x0100 while WAIT is outstanding for 0x0006 -> stale response discarded, next `valid` instruction comes from 0x0100, `pc_plus2`=0x0102.
- `halt_in`=1 -> `imem_req` low within 1 cycle and stays low for 20 cycles despite a `redirect` pulse.
- With `FETCH_ALIGN_CHECK_EN`: redirect to 0x0101 -> `err`=1 next cycle, HALTED, `valid`=0. PC 0xFFFE fetch -> next `imem_addr`=0x0000.
